// File: rtl/memory_stream_reader.sv
// memory_stream_reader
//
// Read-side master for a dual-port memory with a 1-cycle registered read port.
// Walks `length_i` consecutive words starting at `start_addr_i` and presents
// them as a valid/ready stream at up to one word per clock. Addresses wrap from
// DEPTH-1 to 0. The memory's read data is assumed to hold while its read enable
// is low, so a stalled word is simply the held memory output and no skid
// register is needed.
//
// Ports:
//   clock_i                  system clock (memory read clock is the same clock)
//   reset_i                  synchronous, active-high reset
//   start_i                  request a transfer (sampled only when idle)
//   start_addr_i [AW-1:0]    first word address
//   length_i     [AW:0]      number of words, 0..DEPTH
//   abort_i                  cancel the transfer in progress
//   busy_o                   high whenever the reader is not idle
//   done_o                   1-cycle pulse when a transfer completes normally
//   mem_read_clock_enable_o  constant 1
//   mem_read_enable_o        memory read enable
//   mem_read_addr_o [AW-1:0] memory read address
//   mem_read_data_i [W-1:0]  memory read data (registered, held when not enabled)
//   out_valid_o              stream word available
//   out_ready_i              consumer accepts the word
//   out_data_o   [W-1:0]     stream data, pass-through of mem_read_data_i
//   out_last_o               high with out_valid_o on the final word
module memory_stream_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 512,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [AW-1:0]    start_addr_i,
    input  logic [AW:0]      length_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mem_read_clock_enable_o,
    output logic             mem_read_enable_o,
    output logic [AW-1:0]    mem_read_addr_o,
    input  logic [WIDTH-1:0] mem_read_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
    localparam logic [AW-1:0] AddrOne  = AW'(1);
    localparam logic [AW:0]   CntOne   = (AW + 1)'(1);

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   addr_d;
    logic [AW:0]     issue_q;    // reads still to be issued
    logic [AW:0]     deliver_q;  // words still to be handed to the consumer
    logic            out_valid_q;
    logic            rd_en;
    logic            handshake;

    // A read may be issued whenever the output slot is empty or being emptied
    // this cycle; a stalled slot blocks reads so the memory output holds.
    always_comb begin
        rd_en     = (state_q == StRead) && !abort_i && (issue_q != '0) &&
                    (!out_valid_q || out_ready_i);
        handshake = out_valid_q && out_ready_i;
        addr_d    = (addr_q == LastAddr) ? '0 : addr_q + AddrOne;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            issue_q     <= '0;
            deliver_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (length_i != '0) begin
                            state_q   <= StRead;
                            addr_q    <= start_addr_i;
                            issue_q   <= length_i;
                            deliver_q <= length_i;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StRead: begin
                    if (abort_i) begin
                        // The word in flight from the memory is dropped.
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        issue_q     <= '0;
                        deliver_q   <= '0;
                    end else begin
                        if (rd_en) begin
                            addr_q  <= addr_d;
                            issue_q <= issue_q - CntOne;
                        end
                        if (handshake) begin
                            deliver_q <= deliver_q - CntOne;
                        end
                        if (rd_en) begin
                            out_valid_q <= 1'b1;
                        end else if (handshake) begin
                            out_valid_q <= 1'b0;
                        end
                        if (handshake && (deliver_q == CntOne)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        busy_o                  = (state_q != StIdle);
        done_o                  = (state_q == StDone);
        mem_read_clock_enable_o = 1'b1;
        mem_read_enable_o       = rd_en;
        mem_read_addr_o         = addr_q;
        out_valid_o             = out_valid_q;
        out_data_o              = mem_read_data_i;
        out_last_o              = out_valid_q && (deliver_q == CntOne);
    end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Testbench for memory_stream_reader: pairs the reader with a behavioural
// registered-read memory preloaded with mem[i] = i[7:0] and checks the stream
// against an expected-word queue built from the address arithmetic.
module tb_memory_stream_reader;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    start_addr;
    logic [AW:0]      length;
    logic             abort;
    logic             busy;
    logic             done;
    logic             mem_read_clock_enable;
    logic             mem_read_enable;
    logic [AW-1:0]    mem_read_addr;
    logic [WIDTH-1:0] mem_read_data = '0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [WIDTH-1:0] mem [DEPTH];

    always #5 clock = ~clock;

    memory_stream_reader #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock_i                 (clock),
        .reset_i                 (reset),
        .start_i                 (start),
        .start_addr_i            (start_addr),
        .length_i                (length),
        .abort_i                 (abort),
        .busy_o                  (busy),
        .done_o                  (done),
        .mem_read_clock_enable_o (mem_read_clock_enable),
        .mem_read_enable_o       (mem_read_enable),
        .mem_read_addr_o         (mem_read_addr),
        .mem_read_data_i         (mem_read_data),
        .out_valid_o             (out_valid),
        .out_ready_i             (out_ready),
        .out_data_o              (out_data),
        .out_last_o              (out_last)
    );

    // Registered read port that holds its output while not enabled.
    always @(posedge clock) begin
        if (mem_read_enable && mem_read_clock_enable) begin
            mem_read_data <= mem[mem_read_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer. Inputs change 1 time unit after a rising edge, outputs are
    // sampled 1 unit later. Cycle 1 is the first cycle after start is taken.
    task automatic xfer(input int sa, input int len, input int pct, input int stall_word,
                        input int stall_len, input int abort_after, input bit restart);
        int q[$];
        int issued    = 0;
        int hs        = 0;
        int last_hs   = 0;
        int done_cyc  = -1;
        int stall_cnt = 0;
        bit prev_stall = 1'b0;
        logic [WIDTH-1:0] prev_data = '0;
        for (int i = 0; i < len; i++) q.push_back(((sa + i) % DEPTH) & 255);

        @(posedge clock); #1;
        start = 1'b1; start_addr = AW'(sa); length = (AW + 1)'(len);
        out_ready = 1'b1; abort = 1'b0;
        @(posedge clock);
        for (int cyc = 1; cyc <= 8 * len + 30; cyc++) begin
            if (cyc > 1) @(posedge clock);
            #1;
            start = 1'b0;
            abort = (abort_after >= 0) && (hs == abort_after);
            if (restart && cyc == 3) begin
                start = 1'b1; start_addr = AW'(sa + 7); length = (AW + 1)'(3);
            end
            if (stall_len > 0 && hs == stall_word && stall_cnt < stall_len && out_valid) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else if (pct >= 100) begin
                out_ready = 1'b1;
            end else begin
                out_ready = ($urandom_range(99) < pct);
            end
            #1;
            check("busy", busy, 1);
            if (cyc == 1) check("first_valid_gap", out_valid, 0);
            if (cyc == 2 && len > 0) check("first_valid", out_valid, 1);
            if (mem_read_enable) begin
                check("rd_addr", mem_read_addr, (sa + issued) % DEPTH);
                check("rd_count", issued < len, 1);
                issued++;
            end
            if (out_valid && !out_ready) check("stall_no_read", mem_read_enable, 0);
            if (prev_stall) check("stall_hold", out_data, prev_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (abort) begin
                @(posedge clock); #1;
                abort = 1'b0;
                #1;
                check("abort_valid", out_valid, 0);
                check("abort_rd", mem_read_enable, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                @(posedge clock); #2;
                check("abort_no_done", done, 0);
                return;
            end
            if (out_valid && out_ready) begin
                check("extra_word", q.size() > 0, 1);
                if (q.size() > 0) begin
                    check("data", out_data, q[0]);
                    check("last", out_last, q.size() == 1);
                    void'(q.pop_front());
                end
                if (pct >= 100 && stall_len == 0) check("word_cycle", cyc, 2 + hs);
                hs++;
                last_hs = cyc;
            end else if (!out_valid) begin
                check("last_idle", out_last, 0);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check("done_cycle", done_cyc, last_hs + 1);
        check("all_words", q.size(), 0);
        check("issued", issued, len);
        @(posedge clock); #2;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
        reset = 1'b1; start = 1'b0; start_addr = '0; length = '0;
        abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", mem_read_enable, 0);
        check("rst_addr", mem_read_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_ce", mem_read_clock_enable, 1);

        xfer(5, 4, 100, 0, 0, -1, 1'b0);     // basic
        xfer(510, 4, 100, 0, 0, -1, 1'b0);   // address wrap
        xfer(0, 6, 100, 2, 3, -1, 1'b0);     // 3-cycle stall on word 2
        xfer(0, 0, 100, 0, 0, -1, 1'b0);     // zero length
        xfer(20, 8, 100, 0, 0, -1, 1'b1);    // second start ignored
        xfer(30, 8, 100, 0, 0, 2, 1'b0);     // abort after 2 handshakes
        xfer(40, 3, 100, 0, 0, -1, 1'b0);    // new start accepted after abort
        xfer(300, DEPTH, 100, 0, 0, -1, 1'b0); // full memory, wrapping

        repeat (5) xfer($urandom_range(DEPTH - 1), $urandom_range(1, 24), 60, 0, 0, -1, 1'b0);

        // Reset mid-stream while a word is presented.
        @(posedge clock); #1;
        start = 1'b1; start_addr = AW'(50); length = (AW + 1)'(10); out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #2;
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd", mem_read_enable, 0);
        check("mid_rst_addr", mem_read_addr, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_last", out_last, 0);
        xfer(100, 2, 100, 0, 0, -1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
